ex_hazard_sequencer: RTL

Hazard and stall sequencer for the 5-stage RISC-V pipeline. It drives the forwarding selects into the execute stage, inserts load-use bubbles and squashes wrong-path instructions on taken branches and jumps. It also freezes the pipeline while the L1 instruction or data cache services a miss from the 2-level hierarchy. It sits beside the datapath and feeds StallF/StallD/StallE, FlushD/FlushE and ForwardAE/ForwardBE to the stage registers.

---
 rtl/ex_hazard_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ex_hazard_sequencer.sv
// Hazard and stall sequencer for the 5-stage pipeline.
// Drives the EX-stage forwarding selects, load-use bubbles and branch squashes.
// It also freezes the pipeline while either L1 cache services a miss.
// All control outputs are combinational from the current inputs.
// The registered state only feeds the miss timeout and the debug port.
module ex_hazard_sequencer #(
    parameter int MISS_TIMEOUT = 1024,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [1:0]       ResultSrcE,
    input  logic [4:0]       RdM,
    input  logic             RegwriteM,
    input  logic [4:0]       RdW,
    input  logic             RegwriteW,
    input  logic             PCSrcE,
    input  logic             dmem_req_M,
    input  logic             dcache_ready,
    input  logic             icache_ready,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             miss_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        IWAIT = 2'd2
    } state_t;

    localparam int WAIT_W = $clog2(MISS_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MISS_TIMEOUT);

    state_t            curState;
    state_t            nextState;
    logic [WAIT_W-1:0] waitCnt;
    logic              lu;
    logic              dmiss;
    logic              imiss;

    // Hazard conditions seen this cycle
    always_comb begin
        lu    = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                ((RdE == Rs1D) || (RdE == Rs2D));
        dmiss = dmem_req_M && !dcache_ready;
        imiss = !icache_ready;
    end

    // Forwarding selects: memory stage beats writeback, x0 never forwarded
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (rst) begin
            if (RegwriteM && (RdM != 5'd0) && (RdM == Rs1E))
                ForwardAE = 2'b10;
            else if (RegwriteW && (RdW != 5'd0) && (RdW == Rs1E))
                ForwardAE = 2'b01;
            if (RegwriteM && (RdM != 5'd0) && (RdM == Rs2E))
                ForwardBE = 2'b10;
            else if (RegwriteW && (RdW != 5'd0) && (RdW == Rs2E))
                ForwardBE = 2'b01;
        end
    end

    // Stall/flush priority: D-miss freezes everything, then branch, load-use, I-miss
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        if (rst) begin
            if (dmiss) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
                StallF = imiss;
            end else if (lu) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end else if (imiss) begin
                StallF = 1'b1;
                FlushD = 1'b1;
            end
        end
    end

    // Miss-wait state transitions
    always_comb begin
        nextState = curState;
        case (curState)
            RUN: begin
                if (dmiss)
                    nextState = DWAIT;
                else if (imiss)
                    nextState = IWAIT;
            end
            DWAIT: begin
                if (dcache_ready)
                    nextState = RUN;
            end
            IWAIT: begin
                if (dmiss)
                    nextState = DWAIT;
                else if (icache_ready)
                    nextState = RUN;
            end
            default: nextState = RUN;
        endcase
    end

    // State, saturating wait counter, sticky timeout flag and stall counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            curState     <= RUN;
            waitCnt      <= '0;
            miss_err     <= 1'b0;
            stall_cycles <= '0;
        end else begin
            curState <= nextState;
            if (nextState == RUN)
                waitCnt <= '0;
            else if ((curState != RUN) && (waitCnt != WAIT_MAX))
                waitCnt <= waitCnt + 1'b1;
            if ((curState != RUN) && (waitCnt >= WAIT_MAX - 1'b1))
                miss_err <= 1'b1;
            if (StallF)
                stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

    assign state = curState;

endmodule
